// File: rtl/branch_resolve_queue.sv
// In-order queue of IF branch predictions, resolved against EX outcomes to drive predictor updates and fetch redirects.
// Optional saturating resolve/mispredict counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pred_target,
  input  logic [31:0]      alloc_fallthrough,
  input  logic [IDX_W-1:0] alloc_lhr_idx,
  input  logic [IDX_W-1:0] alloc_lhpt_idx,
  input  logic [IDX_W-1:0] alloc_btb_idx,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  input  logic             ext_flush,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic [IDX_W-1:0] upd_lhr_idx,
  output logic [IDX_W-1:0] upd_lhpt_idx,
  output logic [IDX_W-1:0] upd_btb_idx,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err_underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]      stat_resolved,
  output logic [15:0]      stat_mispred
`endif
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [31:0]      fallthrough;
    logic [IDX_W-1:0] lhr_idx;
    logic [IDX_W-1:0] lhpt_idx;
    logic [IDX_W-1:0] btb_idx;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  entry_t head_ent;
  logic   resolve_fire, pred_wrong, mis_comb, alloc_fire;

  logic             upd_valid_q, upd_taken_q, mispredict_q, err_underflow_q;
  logic [31:0]      upd_target_q, redirect_pc_q;
  logic [IDX_W-1:0] upd_lhr_q, upd_lhpt_q, upd_btb_q;

  always_comb begin
    head_ent     = mem_q[head_q];
    empty        = (count_q == '0);
    full         = (count_q == DEPTH_C);
    resolve_fire = resolve_valid && !empty && vld_q[head_q];
    pred_wrong   = (resolve_taken != head_ent.pred_taken) ||
                   (resolve_taken && (resolve_target != head_ent.pred_target));
    mis_comb     = resolve_fire && pred_wrong;
    // A pop frees a slot in the same edge, so a full queue may still accept.
    alloc_ready  = !ext_flush && !mis_comb && (!full || resolve_fire);
    alloc_fire   = alloc_valid && alloc_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (resolve_fire) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_ONE;
    end
    if (ext_flush || mis_comb) begin
      // Squash everything younger: tail collapses onto the post-pop head.
      vld_d   = '0;
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (alloc_fire) begin
        vld_d[tail_q] = 1'b1;
        tail_d        = tail_q + PTR_ONE;
      end
      case ({alloc_fire, resolve_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_q[tail_q] <= '{pred_taken:  alloc_pred_taken,
                         pred_target: alloc_pred_target,
                         fallthrough: alloc_fallthrough,
                         lhr_idx:     alloc_lhr_idx,
                         lhpt_idx:    alloc_lhpt_idx,
                         btb_idx:     alloc_btb_idx};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      upd_valid_q     <= 1'b0;
      upd_taken_q     <= 1'b0;
      upd_target_q    <= '0;
      upd_lhr_q       <= '0;
      upd_lhpt_q      <= '0;
      upd_btb_q       <= '0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      upd_valid_q  <= resolve_fire;
      mispredict_q <= mis_comb && !ext_flush;
      if (resolve_fire) begin
        upd_taken_q  <= resolve_taken;
        upd_target_q <= resolve_target;
        upd_lhr_q    <= head_ent.lhr_idx;
        upd_lhpt_q   <= head_ent.lhpt_idx;
        upd_btb_q    <= head_ent.btb_idx;
      end
      if (mis_comb && !ext_flush) begin
        redirect_pc_q <= resolve_taken ? resolve_target : head_ent.fallthrough;
      end
      if (resolve_valid && empty) begin
        err_underflow_q <= 1'b1;
      end
    end
  end

`ifdef BRQ_STATS_EN
  logic [15:0] stat_res_q, stat_mis_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (resolve_fire && (stat_res_q != '1)) begin
        stat_res_q <= stat_res_q + 16'd1;
      end
      if (mis_comb && !ext_flush && (stat_mis_q != '1)) begin
        stat_mis_q <= stat_mis_q + 16'd1;
      end
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif

  assign upd_valid     = upd_valid_q;
  assign upd_taken     = upd_taken_q;
  assign upd_target    = upd_target_q;
  assign upd_lhr_idx   = upd_lhr_q;
  assign upd_lhpt_idx  = upd_lhpt_q;
  assign upd_btb_idx   = upd_btb_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign count         = count_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed checks of branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             Reset = 1'b1;
  logic             alloc_valid = 1'b0, alloc_pred_taken = 1'b0;
  logic [31:0]      alloc_pred_target = '0, alloc_fallthrough = '0;
  logic [IDX_W-1:0] alloc_lhr_idx = '0, alloc_lhpt_idx = '0, alloc_btb_idx = '0;
  logic             resolve_valid = 1'b0, resolve_taken = 1'b0, ext_flush = 1'b0;
  logic [31:0]      resolve_target = '0;
  logic             alloc_ready, upd_valid, upd_taken, mispredict, full, empty, err_underflow;
  logic [31:0]      upd_target, redirect_pc;
  logic [IDX_W-1:0] upd_lhr_idx, upd_lhpt_idx, upd_btb_idx;
  logic [PTR_W:0]   count;

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .Reset(Reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
    .alloc_fallthrough(alloc_fallthrough), .alloc_lhr_idx(alloc_lhr_idx),
    .alloc_lhpt_idx(alloc_lhpt_idx), .alloc_btb_idx(alloc_btb_idx),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .ext_flush(ext_flush),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_lhr_idx(upd_lhr_idx), .upd_lhpt_idx(upd_lhpt_idx), .upd_btb_idx(upd_btb_idx),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
    .full(full), .empty(empty), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit        pt;
    bit [31:0] tgt;
    bit [31:0] fall;
    bit [3:0]  lhr, lhpt, btb;
  } ment_t;

  ment_t     mq[$];
  bit        m_upd_valid, m_upd_taken, m_mis, m_under;
  bit [31:0] m_upd_target, m_redir;
  bit [3:0]  m_lhr, m_lhpt, m_btb;

  task automatic model_clear();
    mq.delete();
    m_upd_valid = 0; m_upd_taken = 0; m_mis = 0; m_under = 0;
    m_upd_target = 0; m_redir = 0; m_lhr = 0; m_lhpt = 0; m_btb = 0;
  endtask

  task automatic check_state();
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("empty", 64'(empty), 64'(mq.size() == 0));
    check_eq("full", 64'(full), 64'(mq.size() == DEPTH));
    check_eq("upd_valid", 64'(upd_valid), 64'(m_upd_valid));
    check_eq("upd_taken", 64'(upd_taken), 64'(m_upd_taken));
    check_eq("upd_target", 64'(upd_target), 64'(m_upd_target));
    check_eq("upd_lhr_idx", 64'(upd_lhr_idx), 64'(m_lhr));
    check_eq("upd_lhpt_idx", 64'(upd_lhpt_idx), 64'(m_lhpt));
    check_eq("upd_btb_idx", 64'(upd_btb_idx), 64'(m_btb));
    check_eq("mispredict", 64'(mispredict), 64'(m_mis));
    check_eq("err_underflow", 64'(err_underflow), 64'(m_under));
    if (m_mis) check_eq("redirect_pc", 64'(redirect_pc), 64'(m_redir));
  endtask

  task automatic cyc(input bit av, input bit pt, input bit [31:0] ptgt, input bit [31:0] fall,
                     input bit [3:0] l0, input bit [3:0] l1, input bit [3:0] l2,
                     input bit rv, input bit rt, input bit [31:0] rtgt, input bit fl);
    ment_t h, n;
    bit    fr, mis, rdy;
    @(negedge clk);
    alloc_valid = av; alloc_pred_taken = pt; alloc_pred_target = ptgt; alloc_fallthrough = fall;
    alloc_lhr_idx = l0; alloc_lhpt_idx = l1; alloc_btb_idx = l2;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt; ext_flush = fl;
    fr = rv && (mq.size() > 0);
    if (fr) h = mq[0];
    mis = fr && ((rt != h.pt) || (rt && (rtgt != h.tgt)));
    rdy = !fl && !mis && ((mq.size() < DEPTH) || fr);
    #1 check_eq("alloc_ready", 64'(alloc_ready), 64'(rdy));
    @(posedge clk);
    m_upd_valid = fr;
    if (fr) begin
      m_upd_taken = rt; m_upd_target = rtgt; m_lhr = h.lhr; m_lhpt = h.lhpt; m_btb = h.btb;
    end
    if (rv && mq.size() == 0) m_under = 1;
    m_mis = mis && !fl;
    if (m_mis) m_redir = rt ? rtgt : h.fall;
    if (fl || mis) mq.delete();
    else begin
      if (fr) void'(mq.pop_front());
      if (av && rdy) begin
        n.pt = pt; n.tgt = ptgt; n.fall = fall; n.lhr = l0; n.lhpt = l1; n.btb = l2;
        mq.push_back(n);
      end
    end
    #1 check_state();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit pt, input bit [31:0] ptgt, input bit [31:0] fall);
    cyc(1, pt, ptgt, fall, 4'h1, 4'h2, 4'h3, 0, 0, 0, 0);
  endtask

  task automatic resolve(input bit rt, input bit [31:0] rtgt);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, rt, rtgt, 0);
  endtask

  // Reset asserted between clock edges; effect must be visible before any edge.
  task automatic async_reset();
    @(negedge clk);
    alloc_valid = 0; resolve_valid = 0; ext_flush = 0;
    #2 Reset = 1'b1;
    #1;
    model_clear();
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_mispredict", 64'(mispredict), 64'd0);
    check_eq("rst_upd_valid", 64'(upd_valid), 64'd0);
    check_eq("rst_err_underflow", 64'(err_underflow), 64'd0);
    @(negedge clk);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end, got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    Reset = 1'b1;
    #3;
    check_eq("reset_count", 64'(count), 64'd0);
    check_eq("reset_empty", 64'(empty), 64'd1);
    check_eq("reset_full", 64'(full), 64'd0);
    check_eq("reset_mispredict", 64'(mispredict), 64'd0);
    @(negedge clk);
    Reset = 1'b0;

    // Correct taken prediction.
    alloc(1, 32'h40, 32'h14);
    resolve(1, 32'h40);
    check_eq("t1_upd_target", 64'(upd_target), 64'h40);

    // Predicted not-taken, actually taken.
    alloc(0, 32'h0, 32'h24);
    resolve(1, 32'h80);
    check_eq("t2_redirect", 64'(redirect_pc), 64'h80);
    check_eq("t2_mispredict", 64'(mispredict), 64'd1);

    // Fill, overflow attempt, then pop+push at full.
    for (int i = 0; i < DEPTH; i++) alloc(1, 32'h40, 32'h100 + 32'(i * 4));
    alloc(1, 32'h40, 32'h200);
    check_eq("t3_full", 64'(full), 64'd1);
    cyc(1, 1, 32'h40, 32'h204, 4'h5, 4'h6, 4'h7, 1, 1, 32'h40, 0);
    check_eq("t3_count", 64'(count), 64'd4);
    for (int i = 0; i < DEPTH; i++) resolve(1, 32'h40);

    // Head mispredicts while a new allocation is offered.
    alloc(1, 32'h50, 32'h30);
    alloc(0, 32'h0, 32'h34);
    alloc(0, 32'h0, 32'h38);
    cyc(1, 1, 32'h60, 32'h3c, 4'h9, 4'ha, 4'hb, 1, 0, 32'h0, 0);
    check_eq("t4_redirect", 64'(redirect_pc), 64'h30);
    check_eq("t4_count", 64'(count), 64'd0);

    // Resolve on empty queue: sticky underflow.
    resolve(1, 32'h40);
    idle();
    idle();
    check_eq("t5_underflow_sticky", 64'(err_underflow), 64'd1);

    // Async reset with two entries queued.
    alloc(1, 32'h40, 32'h10);
    alloc(1, 32'h40, 32'h18);
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80,
          32'h1000 + 32'($urandom_range(0, 63)) * 4,
          4'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80,
          $urandom_range(0, 19) == 0);
      if (i == 300) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
